// File: rtl/acc_c_id_tracker.sv
// acc_c_id_tracker: attaches interconnect transaction IDs to the in-order
// responses of an ID-less accelerator and caps outstanding requests.
// Optional feature macro: ACC_ID_TRACKER_RSP_REG_EN
//   defined   -> one-entry registered response path (1 cycle latency)
//   undefined -> combinational response path
module acc_c_id_tracker #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned QPayloadWidth  = 128,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // request from interconnect
  input  logic                     slv_q_valid_i,
  output logic                     slv_q_ready_o,
  input  logic [IdWidth-1:0]       slv_q_id_i,
  input  logic [QPayloadWidth-1:0] slv_q_payload_i,
  // request to accelerator
  output logic                     acc_q_valid_o,
  input  logic                     acc_q_ready_i,
  output logic [QPayloadWidth-1:0] acc_q_payload_o,
  // response from accelerator
  input  logic                     acc_p_valid_i,
  output logic                     acc_p_ready_o,
  input  logic [DataWidth-1:0]     acc_p_data0_i,
  input  logic [DataWidth-1:0]     acc_p_data1_i,
  input  logic                     acc_p_dual_writeback_i,
  input  logic [4:0]               acc_p_rd_i,
  input  logic                     acc_p_error_i,
  // response to interconnect
  output logic                     slv_p_valid_o,
  input  logic                     slv_p_ready_i,
  output logic [IdWidth-1:0]       slv_p_id_o,
  output logic [DataWidth-1:0]     slv_p_data0_o,
  output logic [DataWidth-1:0]     slv_p_data1_o,
  output logic                     slv_p_dual_writeback_o,
  output logic [4:0]               slv_p_rd_o,
  output logic                     slv_p_error_o,
  // status
  output logic [CntWidth-1:0]      outstanding_o,
  output logic                     proto_err_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdWidth-1:0]  id_mem [MaxOutstanding];
  logic [PtrWidth-1:0] wptr_q, rptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                proto_err_q;

  logic full, empty, q_hs, p_hs, orphan, fwd_vld, push, pop;
  logic [IdWidth-1:0] head_id;

  // Circular pointer advance; handles non-power-of-two depths.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Request side: full is taken from the registered count only, so a
  // retiring response never unblocks a request in the same cycle.
  assign full            = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty           = (cnt_q == '0);
  assign acc_q_valid_o   = slv_q_valid_i & ~full;
  assign slv_q_ready_o   = acc_q_ready_i & ~full;
  assign acc_q_payload_o = slv_q_payload_i;
  assign q_hs            = slv_q_valid_i & slv_q_ready_o;

  // Response side: an orphan has nothing to pair with (empty, no bypass).
  assign orphan  = acc_p_valid_i & empty & ~q_hs;
  assign fwd_vld = acc_p_valid_i & ~orphan;
  assign p_hs    = acc_p_valid_i & acc_p_ready_o;

  // A push and pop on an empty FIFO bypass the storage entirely.
  assign push    = q_hs & ~(empty & p_hs);
  assign pop     = p_hs & ~empty;
  assign head_id = empty ? slv_q_id_i : id_mem[rptr_q];

  // ID storage: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wptr_q] <= slv_q_id_i;
  end

  // Pointers, outstanding count and sticky protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (p_hs & orphan) proto_err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

`ifdef ACC_ID_TRACKER_RSP_REG_EN
  logic                 vld_p1;
  logic [IdWidth-1:0]   id_p1;
  logic [DataWidth-1:0] data0_p1, data1_p1;
  logic                 dual_p1, err_p1;
  logic [4:0]           rd_p1;

  assign acc_p_ready_o = ~vld_p1 | slv_p_ready_i;

  // ---- stage p1: one-entry response register, holds while stalled ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      data0_p1 <= '0;
      data1_p1 <= '0;
      dual_p1  <= 1'b0;
      rd_p1    <= '0;
      err_p1   <= 1'b0;
    end else if (acc_p_ready_o) begin
      vld_p1 <= fwd_vld;
      if (fwd_vld) begin
        id_p1    <= head_id;
        data0_p1 <= acc_p_data0_i;
        data1_p1 <= acc_p_data1_i;
        dual_p1  <= acc_p_dual_writeback_i;
        rd_p1    <= acc_p_rd_i;
        err_p1   <= acc_p_error_i;
      end
    end
  end

  assign slv_p_valid_o          = vld_p1;
  assign slv_p_id_o             = id_p1;
  assign slv_p_data0_o          = data0_p1;
  assign slv_p_data1_o          = data1_p1;
  assign slv_p_dual_writeback_o = dual_p1;
  assign slv_p_rd_o             = rd_p1;
  assign slv_p_error_o          = err_p1;
`else
  // Orphans are swallowed here, so they are acknowledged regardless of
  // downstream ready. Outputs are forced to zero while reset is held.
  assign acc_p_ready_o          = slv_p_ready_i | orphan;
  assign slv_p_valid_o          = fwd_vld & ~rst_i;
  assign slv_p_id_o             = rst_i ? '0 : head_id;
  assign slv_p_data0_o          = rst_i ? '0 : acc_p_data0_i;
  assign slv_p_data1_o          = rst_i ? '0 : acc_p_data1_i;
  assign slv_p_dual_writeback_o = ~rst_i & acc_p_dual_writeback_i;
  assign slv_p_rd_o             = rst_i ? '0 : acc_p_rd_i;
  assign slv_p_error_o          = ~rst_i & acc_p_error_i;
`endif

endmodule

// File: tb/tb_acc_c_id_tracker.sv
// Scoreboard bench for acc_c_id_tracker; latency-agnostic so it covers both
// the registered and combinational response builds.
module tb_acc_c_id_tracker;
  localparam int DW = 32, IW = 4, PW = 128, MO = 4, CW = 3;

  logic clk, rst_i;
  logic slv_q_valid_i, slv_q_ready_o;
  logic [IW-1:0] slv_q_id_i;
  logic [PW-1:0] slv_q_payload_i;
  logic acc_q_valid_o, acc_q_ready_i;
  logic [PW-1:0] acc_q_payload_o;
  logic acc_p_valid_i, acc_p_ready_o;
  logic [DW-1:0] acc_p_data0_i, acc_p_data1_i;
  logic acc_p_dual_writeback_i, acc_p_error_i;
  logic [4:0] acc_p_rd_i;
  logic slv_p_valid_o, slv_p_ready_i;
  logic [IW-1:0] slv_p_id_o;
  logic [DW-1:0] slv_p_data0_o, slv_p_data1_o;
  logic slv_p_dual_writeback_o, slv_p_error_o;
  logic [4:0] slv_p_rd_o;
  logic [CW-1:0] outstanding_o;
  logic proto_err_o;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        err;
    logic        dual;
    logic [31:0] d0;
    logic [31:0] d1;
  } rsp_t;

  rsp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] wrap_ids [9] = '{4'hA, 4'h1, 4'hF, 4'h0, 4'h5, 4'hB, 4'h3, 4'hC, 4'h8};

  acc_c_id_tracker #(
    .DataWidth(DW), .IdWidth(IW), .QPayloadWidth(PW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_q_valid_i(slv_q_valid_i), .slv_q_ready_o(slv_q_ready_o),
    .slv_q_id_i(slv_q_id_i), .slv_q_payload_i(slv_q_payload_i),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_q_payload_o(acc_q_payload_o),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
    .acc_p_data0_i(acc_p_data0_i), .acc_p_data1_i(acc_p_data1_i),
    .acc_p_dual_writeback_i(acc_p_dual_writeback_i), .acc_p_rd_i(acc_p_rd_i),
    .acc_p_error_i(acc_p_error_i),
    .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(slv_p_ready_i),
    .slv_p_id_o(slv_p_id_o), .slv_p_data0_o(slv_p_data0_o),
    .slv_p_data1_o(slv_p_data1_o), .slv_p_dual_writeback_o(slv_p_dual_writeback_o),
    .slv_p_rd_o(slv_p_rd_o), .slv_p_error_o(slv_p_error_o),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request and hold it until accepted.
  task automatic req(input logic [3:0] id, input logic [127:0] pl);
    int n;
    slv_q_valid_i = 1'b1; slv_q_id_i = id; slv_q_payload_i = pl;
    n = 0;
    @(negedge clk);
    while (!slv_q_ready_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("req_timeout", 0, 1);
    else begin
      chk("acc_q_valid", acc_q_valid_o, 1);
      chk("acc_q_payload", acc_q_payload_o, pl);
    end
    @(posedge clk); #1;
    slv_q_valid_i = 1'b0;
  endtask

  // Drive a response and record the ID the interconnect must see with it.
  task automatic rsp_drive(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d0);
    rsp_t e;
    e.id = id; e.rd = rd; e.err = rd[1]; e.dual = rd[0]; e.d0 = d0; e.d1 = ~d0;
    sbq.push_back(e);
    acc_p_valid_i = 1'b1; acc_p_rd_i = rd; acc_p_data0_i = d0; acc_p_data1_i = ~d0;
    acc_p_dual_writeback_i = rd[0]; acc_p_error_i = rd[1];
  endtask

  task automatic rsp(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d0);
    int n;
    rsp_drive(id, rd, d0);
    n = 0;
    @(negedge clk);
    while (!acc_p_ready_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
    acc_p_valid_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that
  // a stalled output does not change.
  initial begin
    rsp_t got, prev, e;
    logic stall;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got.id = slv_p_id_o; got.rd = slv_p_rd_o; got.err = slv_p_error_o;
      got.dual = slv_p_dual_writeback_o; got.d0 = slv_p_data0_o; got.d1 = slv_p_data1_o;
      if (rst_i) stall = 1'b0;
      else begin
        if (stall) chk("hold_stable", got, prev);
        if (slv_p_valid_o && slv_p_ready_i) begin
          if (sbq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_rsp: got id %0h with no response expected", got.id);
          end else begin
            e = sbq.pop_front();
            chk("rsp_fields", got, e);
          end
        end
        stall = slv_p_valid_o && !slv_p_ready_i;
        prev = got;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    slv_q_valid_i = 0; slv_q_id_i = '0; slv_q_payload_i = '0; acc_q_ready_i = 1'b1;
    acc_p_valid_i = 0; acc_p_data0_i = '0; acc_p_data1_i = '0; acc_p_rd_i = '0;
    acc_p_dual_writeback_i = 0; acc_p_error_i = 0; slv_p_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_cnt", outstanding_o, 0);
    chk("rst_pvalid", slv_p_valid_o, 0);
    chk("rst_proto", proto_err_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_q_ready", slv_q_ready_o, 1);
    @(posedge clk); #1;

    // Single round trip
    req(4'h5, {32{4'hA, 4'h5}});
    repeat (2) @(posedge clk); #1;
    chk("single_cnt1", outstanding_o, 1);
    rsp(4'h5, 5'd7, 32'h1234);
    chk("single_cnt0", outstanding_o, 0);

    // Fill to the cap, then check ordering and no same-cycle unblock
    req(4'h3, 128'h3); req(4'h9, 128'h9); req(4'h1, 128'h1); req(4'hC, 128'hC);
    chk("cnt_full", outstanding_o, 4);
    slv_q_valid_i = 1'b1; slv_q_id_i = 4'hE; slv_q_payload_i = 128'hE;
    @(negedge clk);
    chk("full_q_ready", slv_q_ready_o, 0);
    chk("full_q_valid", acc_q_valid_o, 0);
    @(posedge clk); #1;
    rsp_drive(4'h3, 5'd3, 32'h3333);
    @(negedge clk);
    chk("pop_p_ready", acc_p_ready_o, 1);
    chk("no_same_cycle_unblock", slv_q_ready_o, 0);
    @(posedge clk); #1;
    acc_p_valid_i = 1'b0;
    @(negedge clk);
    chk("unblock_next", slv_q_ready_o, 1);
    @(posedge clk); #1;
    slv_q_valid_i = 1'b0;
    chk("cnt_refill", outstanding_o, 4);
    rsp(4'h9, 5'd9, 32'h9999);
    rsp(4'h1, 5'd1, 32'h1111);
    rsp(4'hC, 5'd12, 32'hCCCC);
    rsp(4'hE, 5'd14, 32'hEEEE);
    chk("cnt_drained", outstanding_o, 0);

    // Same-cycle request and response on an empty tracker
    repeat (2) @(posedge clk); #1;
    slv_q_valid_i = 1'b1; slv_q_id_i = 4'h7; slv_q_payload_i = 128'h7;
    rsp_drive(4'h7, 5'd2, 32'hCAFE);
    @(negedge clk);
    chk("byp_q_ready", slv_q_ready_o, 1);
    chk("byp_p_ready", acc_p_ready_o, 1);
    @(posedge clk); #1;
    slv_q_valid_i = 1'b0; acc_p_valid_i = 1'b0;
    chk("byp_cnt", outstanding_o, 0);
    chk("byp_proto", proto_err_o, 0);

    // Orphan response
    repeat (2) @(posedge clk); #1;
    acc_p_valid_i = 1'b1; acc_p_rd_i = 5'd5; acc_p_data0_i = 32'hBAD;
    @(negedge clk);
    chk("orphan_p_ready", acc_p_ready_o, 1);
    chk("orphan_no_fwd", slv_p_valid_o, 0);
    @(posedge clk); #1;
    acc_p_valid_i = 1'b0;
    chk("orphan_proto", proto_err_o, 1);
    chk("orphan_cnt", outstanding_o, 0);
    @(negedge clk);
    chk("orphan_not_loaded", slv_p_valid_o, 0);
    @(posedge clk); #1;
    req(4'h4, 128'h4);
    rsp(4'h4, 5'd4, 32'h4444);
    chk("proto_sticky", proto_err_o, 1);

    // Downstream stall with two pending responses
    req(4'h6, 128'h6); req(4'h8, 128'h8);
    fork
      begin
        slv_p_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c == 2) chk("stall_p_ready", acc_p_ready_o, 0);
          @(posedge clk);
        end
        #1 slv_p_ready_i = 1'b1;
      end
      begin
        rsp(4'h6, 5'd6, 32'h6666);
        rsp(4'h8, 5'd8, 32'h8888);
      end
    join
    chk("stall_cnt", outstanding_o, 0);

    // Nine overlapped requests: pointer wrap
    fork
      for (int i = 0; i < 9; i++) req(wrap_ids[i], 128'(i + 32'h50));
      begin
        repeat (3) @(posedge clk); #1;
        for (int j = 0; j < 9; j++) rsp(wrap_ids[j], 5'(j + 16), 32'h100 + 32'(j));
      end
    join
    chk("wrap_cnt", outstanding_o, 0);

    // Asynchronous reset with traffic in flight
    req(4'hA, 128'hA); req(4'hB, 128'hB); req(4'hD, 128'hD);
    slv_p_ready_i = 1'b0;
    rsp_drive(4'hA, 5'd9, 32'hDEADBEEF);
    @(posedge clk); #1;
    acc_p_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", slv_p_valid_o, 0);
    chk("arst_id", slv_p_id_o, 0);
    chk("arst_data0", slv_p_data0_o, 0);
    chk("arst_rd", slv_p_rd_o, 0);
    chk("arst_cnt", outstanding_o, 0);
    chk("arst_proto", proto_err_o, 0);
    sbq.delete();
    @(posedge clk); #1;
    rst_i = 1'b0; slv_p_ready_i = 1'b1;
    req(4'h2, 128'h2);
    rsp(4'h2, 5'd1, 32'h2222);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
